// File: rtl/hex_display_ctrl.sv
// Purpose: debounce load/page buttons, snapshot a debug bus and show one page of it as active-low hex digits.
// Latency: press edge to load_ack is 2 + DEB_CYCLES cycles; hex follows snap/page one cycle later.
// Backpressure: none; each debounced press acts exactly once. Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.

// Debounces one active-low button and emits a single-cycle pulse per accepted press.
module hex_display_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {S_UP, S_DOWN_WAIT, S_DOWN, S_UP_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    sync;
  logic          sample;

  assign sample = sync[1];

  // two-flop synchroniser; idles released (1) so reset never looks like a press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], btn_n};
  end

  // state and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_UP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state; the counter clears on every state change and runs only in the wait states
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      S_UP:        if (!sample) state_nxt = S_DOWN_WAIT;
      S_DOWN_WAIT: begin
        if (sample)               state_nxt = S_UP;
        else if (cnt == CNT_MAX)  state_nxt = S_DOWN;
        else                      cnt_nxt   = cnt + CW'(1);
      end
      S_DOWN:      if (sample) state_nxt = S_UP_WAIT;
      S_UP_WAIT: begin
        if (!sample)              state_nxt = S_DOWN;
        else if (cnt == CNT_MAX)  state_nxt = S_UP;
        else                      cnt_nxt   = cnt + CW'(1);
      end
      default:     state_nxt = S_UP;
    endcase
  end

  // press pulse fires in the cycle the down level is accepted; release is silent
  always_comb begin
    press = (state == S_DOWN_WAIT) && !sample && (cnt == CNT_MAX);
  end

endmodule

module hex_display_ctrl #(
  parameter int DIGITS     = 8,
  parameter int PAGES      = 2,
  parameter int DEB_CYCLES = 500000,
  localparam int IN_W      = 4 * DIGITS * PAGES,
  localparam int HEX_W     = 7 * DIGITS,
  localparam int PW        = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in,
  input  logic             load_n,
  input  logic             page_n,
  input  logic             freeze,
  output logic [HEX_W-1:0] hex,
  output logic [PW-1:0]    page,
  output logic             load_ack
);

  localparam int SLICE_W = 4 * DIGITS;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  // display value while in reset: digit 0 shows '0', upper digits '0' or blank
  function automatic logic [HEX_W-1:0] reset_hex();
    logic [HEX_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      r[7*i +: 7] = (i != 0) ? 7'b1111111 : 7'b1000000;
`else
      r[7*i +: 7] = 7'b1000000;
`endif
    end
    return r;
  endfunction

  localparam logic [HEX_W-1:0] HEX_RST = reset_hex();

  logic               load_press, page_press;
  logic [IN_W-1:0]    snap;
  logic [SLICE_W-1:0] slice;
  logic [HEX_W-1:0]   hex_nxt;

  hex_display_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk   (clk),
    .reset (reset),
    .btn_n (load_n),
    .press (load_press)
  );

  hex_display_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_page (
    .clk   (clk),
    .reset (reset),
    .btn_n (page_n),
    .press (page_press)
  );

  // freeze only gates the load; ack marks the cycle snap is written
  assign load_ack = load_press & ~freeze;

  // snapshot capture and page stepping; a simultaneous load and page both apply
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap <= '0;
      page <= '0;
    end else begin
      if (load_ack) snap <= in;
      if (page_press) begin
        if (page == PW'(PAGES - 1)) page <= '0;
        else                        page <= page + PW'(1);
      end
    end
  end

  // select the displayed slice and decode each nibble, blanking leading zeros when enabled
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    slice   = snap[SLICE_W*page +: SLICE_W];
    hex_nxt = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      lead = lead && (slice[4*i +: 4] == 4'h0) && (i != 0);
      hex_nxt[7*i +: 7] = lead ? 7'b1111111 : seg_decode(slice[4*i +: 4]);
`else
      hex_nxt[7*i +: 7] = seg_decode(slice[4*i +: 4]);
`endif
    end
  end

  // registered segment outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hex <= HEX_RST;
    else        hex <= hex_nxt;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised capture-and-display controller for the board's seven-segment bank. It debounces two active-low pushbuttons. On a load press it snapshots a wide debug bus into a holding register. A page button steps through successive 4·DIGITS-bit slices of that snapshot. Each slice is decoded to registered, active-low hexadecimal segment patterns. It sits between the processor's debug outputs and the hex display pins, and it runs entirely in the system clock domain.

## Interface
Parameters:
- DIGITS, 8, number of hex digits driven (1–16)
- PAGES, 2, number of display pages; snapshot width IN_W = 4·DIGITS·PAGES (PAGES ≥ 1)
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level (≥ 2)

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- in  in  IN_W  data bus to snapshot
- load_n  in  1  load pushbutton, active-low, asynchronous to clk
- page_n  in  1  page pushbutton, active-low, asynchronous to clk
- freeze  in  1  level switch; 1 blocks snapshot updates
- hex  out  7·DIGITS  segments; digit i at [7i+6:7i], bit 0 = a … bit 6 = g, 0 = lit
- page  out  clog2(PAGES) (min 1)  currently displayed page index
- load_ack  out  1  one-cycle pulse in the cycle the snapshot register is written

## Operation
- Each button passes through a 2-FF synchroniser and then its own debounce FSM with states S_UP, S_DOWN_WAIT, S_DOWN, S_UP_WAIT. A shared-width counter is cleared on every state change.
- From S_UP, a sampled 0 moves to S_DOWN_WAIT. There the counter runs while the sample stays 0. Reaching DEB_CYCLES−1 moves to S_DOWN and emits a one-cycle press pulse. A sampled 1 before that returns to S_UP with no pulse.
- S_DOWN → S_UP_WAIT → S_UP follows the same rule on release. Release emits no pulse.
- Load pulse with freeze=0: snap ← in as sampled in the pulse cycle, and load_ack=1 in that same cycle.
- Load pulse with freeze=1: ignored; no load_ack.
- Page pulse: page ← page+1, wrapping from PAGES−1 to 0. With PAGES=1, page stays at 0.
- Load and page pulses in the same cycle: both take effect. The next displayed value is the new page of the new snapshot.
- Displayed slice = snap[4·DIGITS·page +: 4·DIGITS]. Digit i shows nibble i of the slice. Decoding is standard 0–F: 0=1000000, 1=1111001, … 8=0000000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset asserted (any time, including mid-debounce):
  - FSMs return to S_UP and counters clear.
  - snap=0, page=0, load_ack=0.
  - Every digit shows '0' (1000000).

## Timing
- hex is registered: it reflects snap/page with 1 cycle latency.
- From a clean press edge on load_n to the load_ack pulse: 2 (synchroniser) + DEB_CYCLES cycles. hex updates on the following edge.
- A glitch of fewer than DEB_CYCLES stable samples never produces a pulse.
- Holding a button down produces exactly one pulse; no auto-repeat.
- freeze is sampled synchronously and is not debounced. It must be stable for the pulse cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Within the displayed slice, the contiguous run of zero nibbles from digit DIGITS−1 downward is blanked (1111111).
  - Digit 0 is never blanked.
  - During reset, digits 1..DIGITS−1 are blank and digit 0 shows '0'.
- Undefined: all digits are always decoded; no blanking logic is present.

## Test plan
(All scenarios use DIGITS=8, PAGES=2, DEB_CYCLES=4.)
- Reset, then release: hex = 8×1000000, page=0, load_ack=0. Assert reset again during S_DOWN_WAIT → all outputs return to reset values and no pulse follows.
- in=0x0000_0000_DEAD_BEEF; hold load_n low for 10 cycles → exactly one load_ack, 6 cycles after the falling edge. Next cycle, digits 7..0 show D,E,A,D,B,E,E,F.
- load_n low for 3 cycles then high → no load_ack, and snap is unchanged.
- freeze=1 with a valid load press → no load_ack, display unchanged. Set freeze=0 and press again → snapshot taken.
- snap=0x1234_5678_9ABC_DEF0; press page twice → page 1 shows 12345678, then page 0 shows 9ABCDEF0. Load and page pulses in the same cycle → new data shown on page 1.
- With LEADING_ZERO_BLANK_EN and slice 0x0000_00A0 → digits 7..2 blank, digit 1 = A, digit 0 = 0. Slice 0 → only digit 0 lit, showing '0'.
